ibex_alu_imd_seq: RTL
=====================

IBEX_ALU_IMD_SEQ -- requirements
Module: ibex_alu_imd_seq

Interface
REQ-001 SHALL have parameter RV32B, default ibex_pkg::RV32BNone, bitmanip config; RV32BNone means no multicycle ALU ops exist.
REQ-002 SHALL have port clk_i  input  1  clock; the block uses one clock.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port en_i  input  1  valid ALU instruction presented.
REQ-005 SHALL have port operator_i  input  ibex_pkg::alu_op_e  requested operation.
REQ-006 SHALL have ports rs1_i, rs2_i, rs3_i  input  32 each  source operands.
REQ-007 SHALL have port result_ready_i  input  1  writeback accepts result.
REQ-008 SHALL have port flush_i  input  1  kill current instruction.
REQ-009 SHALL have ports alu_operator_o, alu_operand_a_o, alu_operand_b_o (32), alu_instr_first_cycle_o (1)  output  drive the ALU.
REQ-010 SHALL have ports imd_val_d_i[2] (32 each), imd_val_we_i (2)  input  intermediate writes from the ALU.
REQ-011 SHALL have port imd_val_q_o[2]  output  32 each  intermediate registers to the ALU.
REQ-012 SHALL have port alu_result_i  input  32  ALU result.
REQ-013 SHALL have ports result_o (32), result_valid_o (1), stall_o (1)  output.

Function
REQ-014 SHALL classify as multicycle ALU_ROR, ALU_ROL, ALU_FSL, ALU_FSR, ALU_CMOV, ALU_CMIX, all ALU_CRC32*/ALU_CRC32C*, ALU_BCOMPRESS, ALU_BDECOMPRESS. This applies only when RV32B != RV32BNone. Otherwise no op is multicycle.
REQ-015 SHALL implement FSM states IDLE and SECOND. SHALL pass alu_operator_o = operator_i and alu_operand_b_o = rs2_i unchanged in both states.
REQ-016 In IDLE:
- alu_instr_first_cycle_o=1.
- alu_operand_a_o=rs1_i.
REQ-017 IDLE, en_i=1, single-cycle op:
- result_valid_o=1 combinationally; latency 0.
- stall_o = ~result_ready_i.
- State stays IDLE.
REQ-018 IDLE, en_i=1, multicycle op, flush_i=0:
- result_valid_o=0 and stall_o=1.
- Next state SECOND.
REQ-019 In SECOND:
- alu_instr_first_cycle_o=0.
- alu_operand_a_o=rs3_i for FSL/FSR/CMOV/CMIX; rs1_i otherwise.
- result_valid_o=en_i & ~flush_i.
- stall_o = ~result_ready_i.
REQ-020 SECOND exits to IDLE when result_ready_i=1, flush_i=1, or en_i=0 (abort). It holds SECOND otherwise, with the result recomputed identically.
REQ-021 flush_i=1 SHALL force result_valid_o=0 and next state IDLE, and takes priority over all other events.
REQ-022 result_o SHALL equal alu_result_i at all times.
REQ-023 Each imd_val_q_o[i] SHALL load imd_val_d_i[i] on the clock edge where imd_val_we_i[i]=1, regardless of state; otherwise it holds.
REQ-024 Upstream holds en_i, operator_i and rs*_i stable while stall_o=1; the block SHALL NOT register operands.
REQ-025 en_i=0 in IDLE SHALL give result_valid_o=0, stall_o=0.

Reset
REQ-026 While rst_ni=0, the following SHALL hold immediately (asynchronously):
- State = IDLE.
- imd_val_q_o[0]=imd_val_q_o[1]=32'h0.
- Combinational outputs follow from IDLE.
REQ-027 Reset asserted in SECOND SHALL abandon the operation with no result_valid_o pulse.

Configuration
REQ-028 Macro IBEX_ALU_IMD_SEQ_CLR_EN defined: both imd registers SHALL clear to 0 on the edge leaving SECOND (completion, flush or abort). A same-edge write is overridden by the clear.
REQ-029 IBEX_ALU_IMD_SEQ_CLR_EN undefined: imd registers SHALL retain stale values until next written.

Verification
REQ-030 ADD, rs1=5, rs2=7, en_i=1, ready=1 -> result_valid_o=1 same cycle, stall_o=0, state IDLE.
REQ-031 RV32B=RV32BOTEarlGrey, ROR rs1=32'h80000001 rs2=1, ready=1 -> cycle0 stall_o=1 valid=0; cycle1 first_cycle=0, result_o=32'hC0000000, valid=1, stall_o=0.
REQ-032 CMOV rs1=32'hAAAA_AAAA rs2=0 rs3=32'h1234_5678 -> cycle1 alu_operand_a_o=32'h1234_5678, result_o=32'h1234_5678.
REQ-033 ROL in SECOND, result_ready_i=0 for 3 cycles -> valid=1 and stall_o=1 held with stable result_o; exit the cycle after ready=1.
REQ-034 flush_i=1 in SECOND -> result_valid_o=0 that cycle, next state IDLE. With IBEX_ALU_IMD_SEQ_CLR_EN, imd_val_q_o both 0 afterwards; without it, the prior values are kept.
REQ-035 RV32B=RV32BNone, ROR issued -> treated single-cycle: valid same cycle, no SECOND entry.

Source files
------------

// File: rtl/ibex_alu_imd_seq.sv
// Sequencer for two-cycle ALU operations plus the ALU's intermediate value registers.
// Optional: define IBEX_ALU_IMD_SEQ_CLR_EN to clear both intermediate registers when SECOND is left.
package ibex_pkg;
  typedef enum integer {
    RV32BNone       = 0,
    RV32BBalanced   = 1,
    RV32BOTEarlGrey = 2,
    RV32BFull       = 3
  } rv32b_e;

  typedef enum logic [5:0] {
    ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND, ALU_XNOR, ALU_ORN, ALU_ANDN,
    ALU_SRA, ALU_SRL, ALU_SLL, ALU_SRO, ALU_SLO, ALU_ROR, ALU_ROL,
    ALU_LT, ALU_LTU, ALU_GE, ALU_GEU, ALU_EQ, ALU_NE,
    ALU_MIN, ALU_MINU, ALU_MAX, ALU_MAXU, ALU_SLT, ALU_SLTU,
    ALU_CMOV, ALU_CMIX, ALU_FSL, ALU_FSR,
    ALU_CRC32_B, ALU_CRC32C_B, ALU_CRC32_H, ALU_CRC32C_H, ALU_CRC32_W, ALU_CRC32C_W,
    ALU_BCOMPRESS, ALU_BDECOMPRESS
  } alu_op_e;
endpackage

module ibex_alu_imd_seq #(
  parameter ibex_pkg::rv32b_e RV32B = ibex_pkg::RV32BNone
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  ibex_pkg::alu_op_e  operator_i,
  input  logic [31:0]        rs1_i,
  input  logic [31:0]        rs2_i,
  input  logic [31:0]        rs3_i,
  input  logic               result_ready_i,
  input  logic               flush_i,
  output ibex_pkg::alu_op_e  alu_operator_o,
  output logic [31:0]        alu_operand_a_o,
  output logic [31:0]        alu_operand_b_o,
  output logic               alu_instr_first_cycle_o,
  input  logic [31:0]        imd_val_d_i [2],
  input  logic [1:0]         imd_val_we_i,
  output logic [31:0]        imd_val_q_o [2],
  input  logic [31:0]        alu_result_i,
  output logic [31:0]        result_o,
  output logic               result_valid_o,
  output logic               stall_o
);
  import ibex_pkg::*;

  // Handshake: result_valid_o offers result_o; it is consumed on a cycle where
  // result_ready_i is also high. stall_o holds upstream, which keeps en_i,
  // operator_i and rs*_i stable, so operands are never registered here.
  typedef enum logic {IDLE = 1'b0, SECOND = 1'b1} state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic        w_multicycle;
  logic        w_use_rs3;
  logic [31:0] r_imd_q [2];

  always_comb begin
    w_multicycle = 1'b0;
    if (RV32B != RV32BNone) begin
      w_multicycle = operator_i inside {ALU_ROR, ALU_ROL, ALU_FSL, ALU_FSR, ALU_CMOV, ALU_CMIX,
                                        ALU_CRC32_B, ALU_CRC32C_B, ALU_CRC32_H, ALU_CRC32C_H,
                                        ALU_CRC32_W, ALU_CRC32C_W, ALU_BCOMPRESS, ALU_BDECOMPRESS};
    end
    w_use_rs3 = operator_i inside {ALU_FSL, ALU_FSR, ALU_CMOV, ALU_CMIX};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (en_i && w_multicycle && !flush_i) w_state_next = SECOND;
      end
      SECOND: begin
        if (flush_i || result_ready_i || !en_i) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    alu_operator_o          = operator_i;
    alu_operand_b_o         = rs2_i;
    alu_operand_a_o         = rs1_i;
    alu_instr_first_cycle_o = 1'b1;
    result_valid_o          = 1'b0;
    stall_o                 = 1'b0;
    case (r_state)
      IDLE: begin
        if (en_i && !flush_i) begin
          result_valid_o = !w_multicycle;
          stall_o        = w_multicycle | ~result_ready_i;
        end
      end
      SECOND: begin
        alu_instr_first_cycle_o = 1'b0;
        alu_operand_a_o         = w_use_rs3 ? rs3_i : rs1_i;
        result_valid_o          = en_i & ~flush_i;
        stall_o                 = ~result_ready_i;
      end
      default: ;
    endcase
  end

  assign result_o = alu_result_i;

`ifdef IBEX_ALU_IMD_SEQ_CLR_EN
  logic w_leave_second;
  assign w_leave_second = (r_state == SECOND) && (w_state_next == IDLE);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_imd_q[0] <= '0;
      r_imd_q[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (imd_val_we_i[i]) r_imd_q[i] <= imd_val_d_i[i];
      end
`ifdef IBEX_ALU_IMD_SEQ_CLR_EN
      // The clear comes last so it wins over a write on the same edge.
      if (w_leave_second) begin
        r_imd_q[0] <= '0;
        r_imd_q[1] <= '0;
      end
`endif
    end
  end

  assign imd_val_q_o = r_imd_q;

endmodule
